// File: rtl/wb_req_master.sv
// wb_req_master: single-outstanding pipelined Wishbone master.
// Turns one valid/ready request into one WB cycle and returns a one-cycle
// response pulse (read data or error). Every cycle is bounded by TIMEOUT.
// Optional feature macro: WB_MASTER_RETRY_EN (rty backs off and retries up
// to MAX_RETRY times instead of failing immediately).
module wb_req_master #(
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [3:0]        req_sel_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    input  logic              wb_stall_i
);

`ifdef WB_MASTER_RETRY_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, BACKOFF} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
`endif

    // The counter must hold TIMEOUT itself: it increments on the abort edge.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Reject parameter values the timing scheme cannot honour.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_req_master: TIMEOUT must be at least 2");
    end
    if (MAX_RETRY < 0) begin : g_bad_max_retry
        $error("wb_req_master: MAX_RETRY must not be negative");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] tmo_cnt;
    logic             accept;
    logic             finish;
    logic             finish_err;
    logic             go_wait;
    logic             timed_out;

`ifdef WB_MASTER_RETRY_EN
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0] retry_cnt;
    logic             retry;
`endif

    assign req_ready_o = (state == IDLE);
    assign accept      = (state == IDLE) && req_valid_i;
    assign timed_out   = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // State register; reset drops any cycle in flight without a response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and termination decode; priority is err > rty > ack > timeout.
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        finish_err = 1'b0;
        go_wait    = 1'b0;
`ifdef WB_MASTER_RETRY_EN
        retry      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    state_next = REQ;
                end
            end
            REQ, WAIT: begin
                if (wb_err_i) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (wb_rty_i) begin
`ifdef WB_MASTER_RETRY_EN
                    if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                        retry = 1'b1;
                    end else begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end
`else
                    finish     = 1'b1;
                    finish_err = 1'b1;
`endif
                end else if (wb_ack_i) begin
                    finish = 1'b1;
                end else if (timed_out) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if ((state == REQ) && !wb_stall_i) begin
                    go_wait = 1'b1;
                end

                if (finish) begin
                    state_next = RESP;
                end else if (go_wait) begin
                    state_next = WAIT;
                end
`ifdef WB_MASTER_RETRY_EN
                else if (retry) begin
                    state_next = BACKOFF;
                end
`endif
            end
            RESP: begin
                state_next = IDLE;
            end
`ifdef WB_MASTER_RETRY_EN
            BACKOFF: begin
                state_next = REQ;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered bus/response outputs and counters; values persist in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_sel_o    <= '0;
            wb_dat_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            tmo_cnt     <= '0;
`ifdef WB_MASTER_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            rsp_valid_o <= 1'b0;
            if (accept) begin
                wb_we_o   <= req_we_i;
                wb_adr_o  <= req_addr_i;
                wb_sel_o  <= req_sel_i;
                wb_dat_o  <= req_wdata_i;
                wb_cyc_o  <= 1'b1;
                wb_stb_o  <= 1'b1;
                tmo_cnt   <= '0;
`ifdef WB_MASTER_RETRY_EN
                retry_cnt <= '0;
`endif
            end
            if ((state == REQ) || (state == WAIT)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (go_wait) begin
                wb_stb_o <= 1'b0;
            end
            if (finish) begin
                wb_cyc_o    <= 1'b0;
                wb_stb_o    <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= finish_err;
                rsp_rdata_o <= (!finish_err && !wb_we_o) ? wb_dat_i : 32'h0;
            end
`ifdef WB_MASTER_RETRY_EN
            if (retry) begin
                wb_cyc_o  <= 1'b0;
                wb_stb_o  <= 1'b0;
                retry_cnt <= retry_cnt + RTY_W'(1);
            end
            if (state == BACKOFF) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                tmo_cnt  <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_req_master.sv
// Self-checking bench for wb_req_master: a scoreboard queue receives the
// expected response when a request is issued and is popped when rsp_valid_o
// pulses. Expectations under WB_MASTER_RETRY_EN follow the same macro.
module tb_wb_req_master;
    localparam int ADDR_W    = 32;
    localparam int TIMEOUT   = 64;
    localparam int MAX_RETRY = 3;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic [3:0]        req_sel_i = '0;
    logic [31:0]       req_wdata_i = '0;
    logic              rsp_valid_o;
    logic              rsp_err_o;
    logic [31:0]       rsp_rdata_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [3:0]        wb_sel_o;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i = 32'hBAD0BAD0;
    logic              wb_ack_i = 1'b0;
    logic              wb_err_i = 1'b0;
    logic              wb_rty_i = 1'b0;
    logic              wb_stall_i = 1'b0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [logic [31:0]];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc_rises = 0;
    int          rsp_count = 0;
    logic        cyc_prev = 1'b0;

    wb_req_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    // Count cyc pulses and response strobes, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (wb_cyc_o && !cyc_prev) cyc_rises++;
        cyc_prev = wb_cyc_o;
        if (rsp_valid_o) rsp_count++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_slave();
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_rty_i   = 1'b0;
        wb_stall_i = 1'b0;
        wb_dat_i   = 32'hBAD0BAD0;
    endtask

    // Presents a request and returns just after its accept edge.
    task automatic start_req(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata);
        int budget;
        budget      = 0;
        req_we_i    = we;
        req_addr_i  = addr;
        req_sel_i   = sel;
        req_wdata_i = wdata;
        req_valid_i = 1'b1;
        while (!req_ready_o && budget < 20) begin
            step();
            budget++;
        end
        if (!req_ready_o) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_wait: req_ready_o=%0b after %0d cycles, required 1", req_ready_o, budget);
        end
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        tests_run++;
        if (req_ready_o !== 1'b1 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: ready=%b cyc=%b stb=%b rsp_valid=%b, required 1 0 0 0",
                     req_ready_o, wb_cyc_o, wb_stb_o, rsp_valid_o);
        end
        tests_run++;
        if (rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0 || wb_adr_o !== '0 || wb_dat_o !== 32'h0 ||
            wb_we_o !== 1'b0 || wb_sel_o !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: err=%b rdata=%h adr=%h dat=%h we=%b sel=%h, required all 0",
                     rsp_err_o, rsp_rdata_o, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_write_stall();
        int   lat;
        int   rises0;
        logic stb_ok;
        exp_t e;
        lat    = -1;
        stb_ok = 1'b1;
        rises0 = cyc_rises;
        wb_stall_i = 1'b1;
        start_req(1'b1, 32'h0, 4'hF, 32'hDEADBEEF);
        model_mem[32'h0] = 32'hDEADBEEF;
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        tests_run++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== 1'b1 || wb_dat_o !== 32'hDEADBEEF ||
            wb_sel_o !== 4'hF || wb_adr_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL write_bus: cyc=%b stb=%b we=%b dat=%h sel=%h adr=%h, required 1 1 1 deadbeef f 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_dat_o, wb_sel_o, wb_adr_o);
        end
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            wb_stall_i = (k <= 2);
            wb_ack_i   = (k == 3);
            step();
            if (rsp_valid_o) lat = k;
            else if (wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1) stb_ok = 1'b0;
        end
        clear_slave();
        tests_run++;
        if (lat != 3 || !stb_ok || wb_cyc_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL write_latency: rsp after %0d cycles stb_held=%b cyc=%b, required 3 1 0", lat, stb_ok, wb_cyc_o);
        end
        if (lat >= 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rsp_err_o !== e.err || rsp_rdata_o !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL write_rsp: err=%b rdata=%h, required %b %h", rsp_err_o, rsp_rdata_o, e.err, e.rdata);
            end
        end
        step();
        tests_run++;
        if (cyc_rises - rises0 != 1 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL write_single_cycle: cyc pulses=%0d rsp_valid=%b ready=%b, required 1 0 1",
                     cyc_rises - rises0, rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_read();
        int   lat;
        logic ready_low;
        exp_t e;
        lat       = -1;
        ready_low = 1'b1;
        start_req(1'b0, 32'h0, 4'hF, 32'h0);
        exp_q.push_back('{err: 1'b0, rdata: model_mem[32'h0]});
        if (req_ready_o !== 1'b0) ready_low = 1'b0;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            wb_ack_i = (k == 1);
            wb_dat_i = (k == 1) ? model_mem[wb_adr_o] : 32'hBAD0BAD0;
            step();
            if (req_ready_o !== 1'b0) ready_low = 1'b0;
            if (rsp_valid_o) lat = k;
        end
        clear_slave();
        tests_run++;
        if (lat != 1 || !ready_low) begin
            tests_failed++;
            $display("[TB] FAIL read_min_latency: rsp after %0d cycles ready_low=%b, required 1 1", lat, ready_low);
        end
        if (lat >= 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rsp_err_o !== e.err || rsp_rdata_o !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL read_rsp: err=%b rdata=%h, required %b %h", rsp_err_o, rsp_rdata_o, e.err, e.rdata);
            end
        end
        step();
    endtask

    task automatic test_timeout();
        int   lat;
        logic wait_ok;
        exp_t e;
        lat     = -1;
        wait_ok = 1'b0;
        start_req(1'b0, 32'h100, 4'hF, 32'h0);
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        for (int k = 1; k <= TIMEOUT + 10 && lat < 0; k++) begin
            step();
            if (k == 1) wait_ok = (wb_cyc_o === 1'b1 && wb_stb_o === 1'b0);
            if (rsp_valid_o) lat = k;
        end
        tests_run++;
        if (!wait_ok || lat != TIMEOUT || wb_cyc_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout: wait_state=%b rsp after %0d cycles cyc=%b, required 1 %0d 0",
                     wait_ok, lat, wb_cyc_o, TIMEOUT);
        end
        if (lat >= 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rsp_err_o !== e.err || rsp_rdata_o !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL timeout_rsp: err=%b rdata=%h, required %b %h", rsp_err_o, rsp_rdata_o, e.err, e.rdata);
            end
        end
        step();
    endtask

    task automatic test_priority();
        int   lat;
        exp_t e;
        // ack and err together: err wins
        lat = -1;
        start_req(1'b0, 32'h0, 4'hF, 32'h0);
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            wb_ack_i = (k == 1);
            wb_err_i = (k == 1);
            wb_dat_i = model_mem[32'h0];
            step();
            if (rsp_valid_o) lat = k;
        end
        clear_slave();
        e = (lat >= 0) ? exp_q.pop_front() : '{err: 1'b1, rdata: 32'h0};
        tests_run++;
        if (lat != 1 || rsp_err_o !== e.err || rsp_rdata_o !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL ack_err_same: lat=%0d err=%b rdata=%h, required 1 %b %h", lat, rsp_err_o, rsp_rdata_o, e.err, e.rdata);
        end
        step();
        // ack on the timeout cycle: ack wins
        lat = -1;
        start_req(1'b0, 32'h0, 4'hF, 32'h0);
        exp_q.push_back('{err: 1'b0, rdata: model_mem[32'h0]});
        for (int k = 1; k <= TIMEOUT + 10 && lat < 0; k++) begin
            wb_ack_i = (k == TIMEOUT);
            wb_dat_i = (k == TIMEOUT) ? model_mem[wb_adr_o] : 32'hBAD0BAD0;
            step();
            if (rsp_valid_o) lat = k;
        end
        clear_slave();
        e = (lat >= 0) ? exp_q.pop_front() : '{err: 1'b0, rdata: 32'h0};
        tests_run++;
        if (lat != TIMEOUT || rsp_err_o !== e.err || rsp_rdata_o !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL ack_on_timeout: lat=%0d err=%b rdata=%h, required %0d %b %h",
                     lat, rsp_err_o, rsp_rdata_o, TIMEOUT, e.err, e.rdata);
        end
        step();
    endtask

    task automatic test_retry();
        int   lat;
        int   rises0;
        int   exp_lat;
        int   exp_rises;
        logic gaps_ok;
        exp_t e;
        lat     = -1;
        gaps_ok = 1'b1;
        rises0  = cyc_rises;
`ifdef WB_MASTER_RETRY_EN
        exp_lat   = 5;
        exp_rises = 3;
        exp_q.push_back('{err: 1'b0, rdata: model_mem[32'h0]});
`else
        exp_lat   = 1;
        exp_rises = 1;
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
`endif
        start_req(1'b0, 32'h0, 4'hF, 32'h0);
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            wb_rty_i = (k == 1 || k == 3);
            wb_ack_i = (k == 5);
            wb_dat_i = (k == 5) ? model_mem[32'h0] : 32'hBAD0BAD0;
            step();
            if (rsp_valid_o) lat = k;
`ifdef WB_MASTER_RETRY_EN
            else if ((k == 1 || k == 3) && wb_cyc_o !== 1'b0) gaps_ok = 1'b0;
            else if ((k == 2 || k == 4) && wb_cyc_o !== 1'b1) gaps_ok = 1'b0;
`endif
        end
        clear_slave();
        e = (lat >= 0) ? exp_q.pop_front() : '{err: 1'b0, rdata: 32'h0};
        tests_run++;
        if (lat != exp_lat || cyc_rises - rises0 != exp_rises || !gaps_ok ||
            rsp_err_o !== e.err || rsp_rdata_o !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL retry: lat=%0d pulses=%0d gaps=%b err=%b rdata=%h, required %0d %0d 1 %b %h",
                     lat, cyc_rises - rises0, gaps_ok, rsp_err_o, rsp_rdata_o, exp_lat, exp_rises, e.err, e.rdata);
        end
        step();
`ifdef WB_MASTER_RETRY_EN
        // rty on every attempt: the rty after MAX_RETRY retries is an error
        lat    = -1;
        rises0 = cyc_rises;
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        start_req(1'b0, 32'h0, 4'hF, 32'h0);
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            wb_rty_i = (k % 2 == 1);
            step();
            if (rsp_valid_o) lat = k;
        end
        clear_slave();
        e = (lat >= 0) ? exp_q.pop_front() : '{err: 1'b1, rdata: 32'h0};
        tests_run++;
        if (lat != 2 * MAX_RETRY + 1 || cyc_rises - rises0 != MAX_RETRY + 1 || rsp_err_o !== e.err) begin
            tests_failed++;
            $display("[TB] FAIL retry_exhaust: lat=%0d pulses=%0d err=%b, required %0d %0d %b",
                     lat, cyc_rises - rises0, rsp_err_o, 2 * MAX_RETRY + 1, MAX_RETRY + 1, e.err);
        end
        step();
`endif
    endtask

    task automatic test_reset_mid_wait();
        int rsp0;
        start_req(1'b1, 32'h20, 4'h3, 32'h0BADF00D);
        step();
        step();
        tests_run++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_wait_state: cyc=%b stb=%b, required 1 0", wb_cyc_o, wb_stb_o);
        end
        rsp0  = rsp_count;
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || wb_adr_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: cyc=%b stb=%b ready=%b rsp_valid=%b adr=%h, required 0 0 1 0 0",
                     wb_cyc_o, wb_stb_o, req_ready_o, rsp_valid_o, wb_adr_o);
        end
        #1;
        rst_i = 1'b0;
        // a late ack arriving while idle must be ignored
        wb_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) step();
        clear_slave();
        tests_run++;
        if (rsp_count != rsp0 || wb_cyc_o !== 1'b0 || req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL idle_ack_ignored: responses=%0d cyc=%b ready=%b, required 0 0 1",
                     rsp_count - rsp0, wb_cyc_o, req_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        lat = -1;
        start_req(1'b1, 32'h40, 4'hF, 32'h12345678);
        model_mem[32'h40] = 32'h12345678;
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        wb_ack_i = 1'b1;
        step();
        clear_slave();
        if (rsp_valid_o) begin
            lat = 1;
            e = exp_q.pop_front();
        end
        // next request is presented during the response cycle
        req_we_i    = 1'b0;
        req_addr_i  = 32'h40;
        req_valid_i = 1'b1;
        step();
        tests_run++;
        if (lat != 1 || req_ready_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready: first rsp lat=%0d ready=%b cyc=%b, required 1 1 0", lat, req_ready_o, wb_cyc_o);
        end
        exp_q.push_back('{err: 1'b0, rdata: model_mem[32'h40]});
        step();
        req_valid_i = 1'b0;
        tests_run++;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h40 || wb_we_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_accept: cyc=%b adr=%h we=%b, required 1 40 0", wb_cyc_o, wb_adr_o, wb_we_o);
        end
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            wb_ack_i = (k == 2);
            wb_dat_i = (k == 2) ? model_mem[wb_adr_o] : 32'hBAD0BAD0;
            step();
            if (rsp_valid_o) lat = k;
        end
        clear_slave();
        e = (lat >= 0) ? exp_q.pop_front() : '{err: 1'b0, rdata: 32'h0};
        tests_run++;
        if (lat != 2 || rsp_err_o !== e.err || rsp_rdata_o !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL b2b_read: lat=%0d err=%b rdata=%h, required 2 %b %h", lat, rsp_err_o, rsp_rdata_o, e.err, e.rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_write_stall();
        test_read();
        test_timeout();
        test_priority();
        test_retry();
        test_reset_mid_wait();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
